// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and latency constants for the multiply-accumulate sequencer.
package mac_seq_ctrl_pkg;

    localparam int ADDR_W  = 9;
    localparam int CNT_W   = 16;
    localparam int MUL_LAT = 6;
    localparam int ADD_LAT = 2;
    localparam int RD_LAT  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COEF   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    // first: beat belongs to pass 0; last: beat belongs to the final pass.
    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic              first;
        logic              last;
    } tag_t;

endpackage

// File: rtl/mac_seq_ctrl_tag_delay.sv
// Fixed-depth shift register of beat tags; 'any' flags a valid tag in flight.
module mac_seq_ctrl_tag_delay
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout,
    output logic any
);

    tag_t stg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    always_comb begin
        any = 1'b0;
        for (int i = 0; i < DEPTH; i++) any = any | stg[i].vld;
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the dense-dense MAC datapath: one coefficient beat plus cfg_rows
// data beats per pass, with BRAM/adder strobes derived from a tag pipeline.
module mac_seq_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int CNT_W   = 16,
    parameter int MUL_LAT = 6,
    parameter int ADD_LAT = 2,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_rows,
    input  logic [CNT_W-1:0]  cfg_passes,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              coef_load,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_bypass,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  pass_idx,
    output logic              busy,
    output logic              done
);
    import mac_seq_ctrl_pkg::*;

    // Below this many rows the next pass would read an element before its write lands.
    localparam logic [ADDR_W:0] DRAIN_ROWS = (ADDR_W+1)'(ADD_LAT + RD_LAT + 1);

    state_t            state, next_state;
    logic [ADDR_W:0]   rows_q;
    logic [CNT_W-1:0]  passes_q;
    logic [ADDR_W-1:0] elem_q;
    logic [CNT_W-1:0]  pass_q;
    logic              done_q;

    tag_t in_tag, rd_tag, byp_tag, wr_tag;
    logic rd_any, byp_any, wr_any, pipe_any;
    logic accept, last_elem, last_pass, cfg_zero, start_ok, flush_end, pass_adv;

    assign accept    = in_valid && in_ready;
    assign last_elem = ({1'b0, elem_q} == rows_q - 1'b1);
    assign last_pass = (pass_q == passes_q - 1'b1);
    assign cfg_zero  = (cfg_rows == '0) || (cfg_passes == '0);
    assign start_ok  = (state == IDLE) && start && !done_q;
    assign pipe_any  = rd_any || byp_any || wr_any;
    assign flush_end = wr_tag.vld && wr_tag.last && ({1'b0, wr_tag.addr} == rows_q - 1'b1);
    assign pass_adv  = (next_state == COEF) && ((state == STREAM) || (state == DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start_ok && !cfg_zero) next_state = COEF;
            COEF:   if (accept) next_state = STREAM;
            STREAM: if (accept && last_elem) begin
                        if (last_pass)                next_state = FLUSH;
                        else if (rows_q < DRAIN_ROWS) next_state = DRAIN;
                        else                          next_state = COEF;
                    end
            DRAIN:  if (!pipe_any) next_state = COEF;
            FLUSH:  if (flush_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == COEF) || (state == STREAM);
        coef_load = (state == COEF) && in_valid;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q   <= '0;
            passes_q <= '0;
            elem_q   <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (start_ok && cfg_zero) || ((state == FLUSH) && flush_end);
            if (start_ok && !cfg_zero) begin
                rows_q   <= cfg_rows;
                passes_q <= cfg_passes;
                pass_q   <= '0;
            end
            if ((state == COEF) && accept)
                elem_q <= '0;
            else if ((state == STREAM) && accept)
                elem_q <= last_elem ? '0 : elem_q + 1'b1;
            if (pass_adv)
                pass_q <= pass_q + 1'b1;
            else if ((state == FLUSH) && flush_end)
                pass_q <= '0;
        end
    end

    always_comb begin
        in_tag.vld   = (state == STREAM) && accept;
        in_tag.addr  = elem_q;
        in_tag.first = (pass_q == '0);
        in_tag.last  = last_pass;
    end

    // Chained taps: read strobe, adder operand select, then write strobe.
    mac_seq_ctrl_tag_delay #(.DEPTH(MUL_LAT - RD_LAT)) u_rd_dly (
        .clk(clk), .rst(rst), .din(in_tag), .dout(rd_tag), .any(rd_any));
    mac_seq_ctrl_tag_delay #(.DEPTH(RD_LAT)) u_byp_dly (
        .clk(clk), .rst(rst), .din(rd_tag), .dout(byp_tag), .any(byp_any));
    mac_seq_ctrl_tag_delay #(.DEPTH(ADD_LAT)) u_wr_dly (
        .clk(clk), .rst(rst), .din(byp_tag), .dout(wr_tag), .any(wr_any));

    assign rd_en      = rd_tag.vld;
    assign rd_addr    = rd_tag.addr;
    assign acc_bypass = byp_tag.vld && byp_tag.first;
    assign wr_en      = wr_tag.vld;
    assign wr_addr    = wr_tag.addr;
    assign out_valid  = wr_tag.vld && wr_tag.last;
    assign out_addr   = wr_tag.addr;
    assign pass_idx   = pass_q;
    assign done       = done_q;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the dense-dense multiply-accumulate datapath: scalar-times-stream multipliers, pipelined adders and partial-sum BRAMs.
- Replaces hard-wired shift-register timing with an FSM, beat counters and a latency-tracking valid pipeline.
- Accepts one coefficient beat plus cfg_rows data beats per pass, for cfg_passes passes.
- Generates coefficient latch, adder bypass, BRAM read/write strobes and addresses, and flags final sums.

Parameters:
ADDR_W, 9, partial-sum BRAM address width; cfg_rows <= 2^ADDR_W
CNT_W, 16, width of cfg_passes and the pass counter
MUL_LAT, 6, multiplier latency in cycles (operand to P)
ADD_LAT, 2, adder latency in cycles (A/B to S)
RD_LAT, 1, BRAM read latency in cycles (addrb to doutb)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when IDLE, ignored otherwise
cfg_rows  in  ADDR_W+1  elements per pass; sampled on accepted start
cfg_passes  in  CNT_W  passes per job; sampled on accepted start
in_valid  in  1  source has a beat on the data bus
in_ready  out  1  controller accepts the beat this cycle
coef_load  out  1  latch current data into the multiplier constant register
rd_en  out  1  partial-sum BRAM read strobe
rd_addr  out  ADDR_W  partial-sum read address
acc_bypass  out  1  adder ignores the BRAM operand (first pass)
wr_en  out  1  partial-sum BRAM write strobe
wr_addr  out  ADDR_W  partial-sum write address
out_valid  out  1  adder output is a final product element
out_addr  out  ADDR_W  row index of the out_valid element
pass_idx  out  CNT_W  current pass number
busy  out  1  job in progress
done  out  1  one-cycle pulse after the last final write

Behaviour:
- Reset: all outputs 0, counters 0, valid pipeline cleared, state IDLE. Reset asserted mid-job aborts the job; no done pulse.
- Beat accepted = in_valid && in_ready. Accepted data beat at cycle t for element e in pass p:
  - multiplier input is the bus at t;
  - rd_en=1, rd_addr=e at t+MUL_LAT-RD_LAT;
  - acc_bypass=(p==0) at t+MUL_LAT;
  - wr_en=1, wr_addr=e at t+MUL_LAT+ADD_LAT;
  - out_valid=1, out_addr=e in the same cycle when p==cfg_passes-1.
- Per-beat tags (valid, addr, first, last) travel in a shift pipeline; idle source cycles create bubbles with no strobes. Bubbles never reorder or drop elements.
- States:
  - IDLE: in_ready=0. On start:
    - zero cfg_rows or zero cfg_passes → done pulse next cycle, stay IDLE;
    - otherwise latch config, busy=1, go to COEF.
  - COEF: in_ready=1. Accepted beat → coef_load=1 that cycle, element counter cleared, go to STREAM.
  - STREAM: in_ready=1. Each accepted beat increments e. On the beat with e==cfg_rows-1:
    - last pass → go to FLUSH;
    - cfg_rows < ADD_LAT+RD_LAT+1 → go to DRAIN (read-after-write hazard across passes);
    - otherwise pass_idx+1 and go to COEF.
  - DRAIN: in_ready=0 until the tag pipeline is empty, then pass_idx+1 and go to COEF.
  - FLUSH: in_ready=0 until the final wr_en has been issued. Next cycle: done=1, busy=0, pass_idx=0, go to IDLE.
- coef_load is never asserted while data beats of the previous pass are still at the multiplier input. The constant is consumed registered, so no hold is needed.
- Address wrap: e counts 0..cfg_rows-1 and is never driven beyond.
- start during busy: ignored. start and done in the same cycle: start is ignored (still busy that edge).

Decomposition:
- Shared package: latency constants (MUL_LAT, ADD_LAT, RD_LAT), state enum (IDLE, COEF, STREAM, DRAIN, FLUSH), beat tag struct {vld, addr, first, last}.
- Sub-module tag_delay: parameterised-depth shift register of tags with an "any valid" output. It is instantiated for the read and write taps and used for the drain/flush empty checks.

Test Plan:
- cfg_rows=4, cfg_passes=3, continuous in_valid; accept at t=0 coef, t=1..4 data:
  - expect rd_en at t=6..9, wr_en at t=9..12 with addrs 0..3;
  - pass 0 shows acc_bypass=1;
  - pass 2 shows out_valid with out_addr 0..3;
  - a single done follows the last write.
- Same config with in_valid low every other cycle: strobes keep addr order 0..3 with bubbles, no duplicate writes, wr_en count = 12.
- cfg_rows=2 (< ADD_LAT+RD_LAT+1): in_ready low in DRAIN between passes. No rd_en to addr e before the previous pass's wr_en to e.
- cfg_rows=0, start: done next cycle, in_ready never asserted. start pulsed while busy: no restart, cfg unchanged.
- rst asserted mid-STREAM of pass 1: all outputs 0 asynchronously, no done. A fresh start completes a 1-pass job with acc_bypass=1 and out_valid on every write.
